eth_rx_fcs_check: RTL and testbench
===================================

# eth_rx_fcs_check

Receive-side front end of the Ethernet path. Takes the raw GMII-style byte stream from the PHY and strips the preamble and SFD. It computes and checks CRC-32, strips the 4-byte FCS, and presents each frame as an AXI-Stream with `tlast` and a per-frame `bad_frame` flag on the last beat. It feeds `axis_fifo` directly, which discards frames flagged bad, so the output has no backpressure (no `tready`).

## Interface
- `MIN_FRAME`, 64, minimum legal length in bytes counted after SFD, including FCS.
- `MAX_FRAME`, 1518, maximum legal length in bytes counted after SFD, including FCS.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `gmii_rxd`  in  8  receive byte.
- `gmii_rx_dv`  in  1  receive data valid; high for the whole preamble, SFD, data and FCS.
- `gmii_rx_er`  in  1  PHY receive error.
- `m_axis_tdata`  out  8  frame byte, FCS removed.
- `m_axis_tvalid`  out  1  beat valid; no ready, so the consumer must accept every beat.
- `m_axis_tlast`  out  1  last data byte of the frame.
- `bad_frame`  out  1  frame-error flag; meaningful only when `tvalid & tlast`, 0 otherwise.
- `stat_good`  out  16  count of frames ended with `bad_frame=0`; wraps.
- `stat_bad`  out  16  count of frames ended with `bad_frame=1`; wraps.

## Operation
- State machine IDLE / PREAMBLE / PAYLOAD / DROP:
  - IDLE: `dv & rxd==8'h55` → PREAMBLE. `dv` with any other byte → DROP.
  - PREAMBLE: `rxd==8'h55` → stay, with no count limit. `rxd==8'hD5` → PAYLOAD and clear CRC, length and error state. Any other byte → DROP. `!dv` → IDLE.
  - PAYLOAD: every `dv` cycle shifts `rxd` into a 5-byte delay line, increments the length counter and updates the CRC. `!dv` → IDLE and runs the end-of-frame action.
  - DROP: no output; wait for `!dv` → IDLE.
- Output path: once the delay line holds 5 bytes, each new byte pushes out the oldest as a beat with `tlast=0`.
- End of frame, on the first `!dv` sample in PAYLOAD:
  - The delay line holds the last data byte plus the 4 FCS bytes. Emit the last data byte with `tlast=1` and `bad_frame` per the rule below.
  - Bump the matching stat counter.
- Frames with fewer than 5 bytes after SFD emit nothing and count nothing.
- CRC-32: IEEE 802.3 polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, byte-wide update, computed over data plus FCS. The frame is good when the register equals residue 32'hC704DD7B, before any final inversion.
- `bad_frame` = CRC mismatch | (`gmii_rx_er` seen on any `dv` cycle in PAYLOAD) | `len < MIN_FRAME` | `len > MAX_FRAME`.
- Length counter is 16 bits and saturates at 16'hFFFF.
- Oversized frames are streamed in full and flagged bad; they are not truncated.

## Timing
- Reset: `m_axis_tvalid=0`, `tlast=0`, `bad_frame=0`, `tdata=0`, stat counters 0, state IDLE, delay line empty.
- All outputs are registered.
- Latency: data byte i (0 = first byte after SFD) appears on `m_axis` in the cycle after byte i+5 is sampled.
- The `tlast` beat appears in the cycle after the first `dv=0` sample.
- Beats of one frame are contiguous: `tvalid` stays high from the first beat to `tlast`, with no gaps.
- Stat counters update on the same edge that presents the `tlast` beat.
- Inter-frame gap: one `dv=0` cycle is sufficient. The `tlast` beat may coincide with the next frame's first preamble byte being sampled, and both are handled.
- Reset asserted mid-frame: outputs clear immediately (asynchronously) and no `tlast` is produced. If reset is released while `dv` is high, the block resynchronises on the next valid preamble or via DROP.
- `gmii_rx_er` outside PAYLOAD is ignored.

## Test plan
- 64-byte frame: 7×0x55, 0xD5, data 0x00..0x3B, correct FCS → 60 beats with `tdata` 0x00..0x3B contiguous, `tlast` only on 0x3B, `bad_frame=0`, `stat_good=1`. First beat appears 6 cycles after data byte 0 is sampled.
- Same frame with the last FCS byte XOR 0x01 → 60 beats, `bad_frame=1` on the 0x3B beat only, `stat_bad=1`.
- Same frame with `gmii_rx_er=1` for one cycle at data byte 10 → all 60 beats delivered, `bad_frame=1`.
- Runt: 16 data bytes plus valid FCS (20 bytes) → 16 beats, `bad_frame=1`. Frame of 3 bytes after SFD → no `tvalid`, stats unchanged.
- Corrupt preamble (0x54 as the 3rd byte) followed by a valid 64-byte body → no `tvalid` for the whole `dv` burst, stats unchanged.
- Two valid 64-byte frames separated by a 1-cycle `dv` gap → 120 beats, two `tlast`, `stat_good=2`. Then assert `rst_n=0` at data byte 30 of a third frame → `tvalid` falls at once, no `tlast`. A following clean frame is received with `bad_frame=0`.

Source files
------------

// File: rtl/eth_rx_fcs_check_if.sv
// GMII receive inputs and AXI-Stream frame output of the Ethernet RX FCS checker.
// The master modport is the checker itself; the slave modport is the PHY/consumer side.
interface eth_rx_fcs_check_if;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       bad_frame;

  modport master (
    input  gmii_rxd,
    input  gmii_rx_dv,
    input  gmii_rx_er,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    output bad_frame
  );

  modport slave (
    output gmii_rxd,
    output gmii_rx_dv,
    output gmii_rx_er,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    input  bad_frame
  );
endinterface

// File: rtl/eth_rx_fcs_check.sv
// Ethernet RX front end: strips preamble/SFD, checks CRC-32, strips the FCS and
// streams each frame as AXI-Stream with a bad_frame flag on the tlast beat.
module eth_rx_fcs_check #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic               clk,
  input  logic               rst_n,
  eth_rx_fcs_check_if.master bus,
  output logic [15:0]        stat_good_o,
  output logic [15:0]        stat_bad_o
);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    DROP
  } state_e;

  localparam logic [15:0] MinLen  = 16'(MIN_FRAME);
  localparam logic [15:0] MaxLen  = 16'(MAX_FRAME);
  localparam logic [31:0] Residue = 32'hC704DD7B;

  state_e          state_q, state_d;
  logic [4:0][7:0] dly_q, dly_d;
  logic [2:0]      fill_q, fill_d;
  logic [15:0]     len_q, len_d;
  logic [31:0]     crc_q, crc_d;
  logic            err_q, err_d;
  logic [7:0]      tdata_q, tdata_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic            bad_q, bad_d;
  logic [15:0]     good_q, good_d;
  logic [15:0]     badcnt_q, badcnt_d;

  logic [31:0]     crcNext;
  logic [31:0]     crcRev;
  logic            frameBad;

  // Reflected (LSB-first) byte-wide CRC-32 update.
  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    fill_d   = fill_q;
    len_d    = len_q;
    crc_d    = crc_q;
    err_d    = err_q;
    tdata_d  = '0;
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    bad_d    = 1'b0;
    good_d   = good_q;
    badcnt_d = badcnt_q;

    crcNext = crcByte(crc_q, bus.gmii_rxd);

    // The register is kept reflected, so the residue is compared bit-reversed.
    crcRev = '0;
    for (int i = 0; i < 32; i++) begin
      crcRev[i] = crc_q[31-i];
    end
    frameBad = (crcRev != Residue) | err_q | (len_q < MinLen) | (len_q > MaxLen);

    case (state_q)
      IDLE: begin
        if (bus.gmii_rx_dv) begin
          state_d = (bus.gmii_rxd == 8'h55) ? PREAMBLE : DROP;
        end
      end

      PREAMBLE: begin
        if (!bus.gmii_rx_dv) begin
          state_d = IDLE;
        end else if (bus.gmii_rxd == 8'hD5) begin
          state_d = PAYLOAD;
          fill_d  = '0;
          len_d   = '0;
          crc_d   = '1;
          err_d   = 1'b0;
        end else if (bus.gmii_rxd != 8'h55) begin
          state_d = DROP;
        end
      end

      PAYLOAD: begin
        if (bus.gmii_rx_dv) begin
          dly_d  = {dly_q[3:0], bus.gmii_rxd};
          fill_d = (fill_q == 3'd5) ? fill_q : fill_q + 3'd1;
          len_d  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
          crc_d  = crcNext;
          err_d  = err_q | bus.gmii_rx_er;
          if (fill_q == 3'd5) begin
            tdata_d  = dly_q[4];
            tvalid_d = 1'b1;
          end
        end else begin
          // End of frame: the oldest byte is the last data byte, the rest is FCS.
          state_d = IDLE;
          if (fill_q == 3'd5) begin
            tdata_d  = dly_q[4];
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            bad_d    = frameBad;
            if (frameBad) begin
              badcnt_d = badcnt_q + 16'd1;
            end else begin
              good_d = good_q + 16'd1;
            end
          end
        end
      end

      DROP: begin
        if (!bus.gmii_rx_dv) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dly_q    <= '0;
      fill_q   <= '0;
      len_q    <= '0;
      crc_q    <= '1;
      err_q    <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      bad_q    <= 1'b0;
      good_q   <= '0;
      badcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      fill_q   <= fill_d;
      len_q    <= len_d;
      crc_q    <= crc_d;
      err_q    <= err_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      bad_q    <= bad_d;
      good_q   <= good_d;
      badcnt_q <= badcnt_d;
    end
  end

  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.bad_frame     = bad_q;
  assign stat_good_o       = good_q;
  assign stat_bad_o        = badcnt_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Bench for eth_rx_fcs_check: directed and random GMII bursts, every beat checked
// against a frame-level model (expected bytes, flags and arrival cycle).
module tb_eth_rx_fcs_check;

  typedef logic [7:0] byteq_t [$];
  typedef bit bitq_t [$];
  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic        bad;
    int unsigned cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] statGood;
  logic [15:0] statBad;

  int unsigned cyc = 0;
  int          nChecks = 0;
  int          nErrors = 0;
  int          beatCount = 0;
  int          lastCount = 0;
  int          expGood = 0;
  int          expBad = 0;
  bit          prevOpen = 1'b0;
  beat_t       expQ [$];

  eth_rx_fcs_check_if busIf();

  eth_rx_fcs_check #(
    .MIN_FRAME(64),
    .MAX_FRAME(1518)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (busIf),
    .stat_good_o(statGood),
    .stat_bad_o (statBad)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    nChecks++;
    nErrors++;
    $display("[TB] FAIL %s: got an event that should not happen (cycle %0d)", name, cyc);
  endtask

  // Plain textbook CRC-32 of the first n bytes, returned already inverted.
  function automatic logic [31:0] crc32(input byteq_t d, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, d[i]};
      for (int j = 0; j < 8; j++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  function automatic logic frameBadModel(input byteq_t body, input bit erAny);
    int n;
    logic [31:0] fcs;
    n = body.size();
    fcs = {body[n-1], body[n-2], body[n-3], body[n-4]};
    return (crc32(body, n - 4) != fcs) || erAny || (n < 64) || (n > 1518);
  endfunction

  // Index of the first byte after the SFD, or -1 when the burst never syncs.
  function automatic int syncPoint(input byteq_t b);
    int i;
    i = 0;
    if (b.size() == 0 || b[0] != 8'h55) return -1;
    while (i < b.size() && b[i] == 8'h55) i++;
    if (i >= b.size() || b[i] != 8'hD5) return -1;
    return i + 1;
  endfunction

  function automatic byteq_t makeFrame(input byteq_t data, input bit corrupt, input int preLen);
    byteq_t b;
    logic [31:0] fcs;
    for (int i = 0; i < preLen; i++) b.push_back(8'h55);
    b.push_back(8'hD5);
    foreach (data[i]) b.push_back(data[i]);
    fcs = crc32(data, data.size());
    b.push_back(fcs[7:0]);
    b.push_back(fcs[15:8]);
    b.push_back(fcs[23:16]);
    b.push_back(fcs[31:24]);
    if (corrupt) b[b.size()-1] = b[b.size()-1] ^ 8'h01;
    return b;
  endfunction

  function automatic bitq_t zeros(input int n);
    bitq_t q;
    for (int i = 0; i < n; i++) q.push_back(1'b0);
    return q;
  endfunction

  task automatic applyStimulus(input byteq_t burst, input bitq_t erq, input int gap, input int abortAt);
    int     bs;
    int     n;
    logic   bad;
    bit     erAny;
    bit     aborted;
    byteq_t body;
    erAny   = 1'b0;
    aborted = 1'b0;
    bad     = 1'b0;
    bs      = syncPoint(burst);
    if (bs >= 0) begin
      for (int k = bs; k < burst.size(); k++) begin
        body.push_back(burst[k]);
        erAny |= erq[k];
      end
    end
    n = body.size();
    if (n >= 5) bad = frameBadModel(body, erAny);

    for (int k = 0; k < burst.size(); k++) begin
      @(posedge clk);
      #1;
      if (abortAt >= 0 && bs >= 0 && k == bs + abortAt) begin
        rst_n   = 1'b0;
        aborted = 1'b1;
        while (expQ.size() > 0 && expQ[expQ.size()-1].cyc >= cyc) void'(expQ.pop_back());
        #1;
        checkOutput("abortValid", 32'(busIf.m_axis_tvalid), 32'd0);
        checkOutput("abortTlast", 32'(busIf.m_axis_tlast), 32'd0);
      end
      if (aborted && k == bs + abortAt + 3) rst_n = 1'b1;
      busIf.gmii_rxd   = burst[k];
      busIf.gmii_rx_dv = 1'b1;
      busIf.gmii_rx_er = erq[k];
      if (!aborted && bs >= 0 && k - bs >= 5) begin
        expQ.push_back('{data: body[k-bs-5], last: 1'b0, bad: 1'b0, cyc: cyc + 1});
      end
    end

    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      if (aborted) rst_n = 1'b1;
      busIf.gmii_rxd   = 8'($urandom);
      busIf.gmii_rx_dv = 1'b0;
      busIf.gmii_rx_er = 1'($urandom);
      if (g == 0 && !aborted && n >= 5) begin
        expQ.push_back('{data: body[n-5], last: 1'b1, bad: bad, cyc: cyc + 1});
      end
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Per-cycle compare of the DUT output against the expected beat queue.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      checkOutput("resetValid", 32'(busIf.m_axis_tvalid), 32'd0);
      checkOutput("resetTlast", 32'(busIf.m_axis_tlast), 32'd0);
      checkOutput("resetBad", 32'(busIf.bad_frame), 32'd0);
      checkOutput("resetData", 32'(busIf.m_axis_tdata), 32'd0);
      checkOutput("resetGood", 32'(statGood), 32'd0);
      checkOutput("resetBadCnt", 32'(statBad), 32'd0);
      expGood  = 0;
      expBad   = 0;
      prevOpen = 1'b0;
    end else begin
      if (busIf.m_axis_tvalid) begin
        if (expQ.size() == 0) begin
          failNow("unexpectedBeat");
          prevOpen = 1'b0;
        end else begin
          e = expQ.pop_front();
          checkOutput("beatData", 32'(busIf.m_axis_tdata), 32'(e.data));
          checkOutput("beatLast", 32'(busIf.m_axis_tlast), 32'(e.last));
          checkOutput("beatBad", 32'(busIf.bad_frame), 32'(e.bad));
          checkOutput("beatCycle", cyc, e.cyc);
          if (e.last) begin
            if (e.bad) expBad++;
            else expGood++;
            lastCount++;
          end
          beatCount++;
          prevOpen = !e.last;
        end
      end else begin
        if (prevOpen) failNow("beatGap");
        prevOpen = 1'b0;
        checkOutput("idleTlast", 32'(busIf.m_axis_tlast), 32'd0);
        checkOutput("idleBad", 32'(busIf.bad_frame), 32'd0);
      end
      checkOutput("statGood", 32'(statGood), 32'(expGood[15:0]));
      checkOutput("statBad", 32'(statBad), 32'(expBad[15:0]));
    end
  end

  initial begin
    byteq_t data64;
    byteq_t data16;
    byteq_t pin;
    byteq_t b;
    byteq_t d;
    bitq_t  erq;
    string  pinStr;
    int     kind;
    int     preLen;

    busIf.gmii_rxd   = 8'h00;
    busIf.gmii_rx_dv = 1'b0;
    busIf.gmii_rx_er = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    pinStr = "123456789";
    for (int i = 0; i < pinStr.len(); i++) pin.push_back(pinStr[i]);
    checkOutput("modelCrcPin", crc32(pin, pin.size()), 32'hCBF43926);

    for (int i = 0; i < 60; i++) data64.push_back(8'(i));
    for (int i = 0; i < 16; i++) data16.push_back(8'(8'hA0 + i));

    b = makeFrame(data64, 1'b0, 7);
    applyStimulus(b, zeros(b.size()), 2, -1);
    settle();
    checkOutput("goodFrameBeats", 32'(beatCount), 32'd60);
    checkOutput("goodFrameStat", 32'(statGood), 32'd1);
    checkOutput("goodFrameBadStat", 32'(statBad), 32'd0);

    b = makeFrame(data64, 1'b1, 7);
    applyStimulus(b, zeros(b.size()), 2, -1);
    settle();
    checkOutput("fcsErrBeats", 32'(beatCount), 32'd120);
    checkOutput("fcsErrStat", 32'(statBad), 32'd1);

    b = makeFrame(data64, 1'b0, 7);
    erq = zeros(b.size());
    erq[8 + 10] = 1'b1;
    applyStimulus(b, erq, 2, -1);
    settle();
    checkOutput("rxErBeats", 32'(beatCount), 32'd180);
    checkOutput("rxErStat", 32'(statBad), 32'd2);

    b = makeFrame(data16, 1'b0, 7);
    applyStimulus(b, zeros(b.size()), 2, -1);
    settle();
    checkOutput("runtBeats", 32'(beatCount), 32'd196);
    checkOutput("runtStat", 32'(statBad), 32'd3);

    b = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h11, 8'h22, 8'h33};
    applyStimulus(b, zeros(b.size()), 2, -1);
    settle();
    checkOutput("shortBeats", 32'(beatCount), 32'd196);
    checkOutput("shortStatGood", 32'(statGood), 32'd1);
    checkOutput("shortStatBad", 32'(statBad), 32'd3);

    b = makeFrame(data64, 1'b0, 7);
    b[2] = 8'h54;
    applyStimulus(b, zeros(b.size()), 2, -1);
    settle();
    checkOutput("badPreambleBeats", 32'(beatCount), 32'd196);

    b = makeFrame(data64, 1'b0, 7);
    applyStimulus(b, zeros(b.size()), 1, -1);
    applyStimulus(b, zeros(b.size()), 2, -1);
    settle();
    checkOutput("backToBackBeats", 32'(beatCount), 32'd316);
    checkOutput("backToBackStat", 32'(statGood), 32'd3);
    checkOutput("backToBackLast", 32'(lastCount), 32'd6);

    applyStimulus(b, zeros(b.size()), 2, 30);
    settle();
    checkOutput("abortBeats", 32'(beatCount), 32'd340);
    checkOutput("abortLast", 32'(lastCount), 32'd6);
    checkOutput("abortStatGood", 32'(statGood), 32'd0);

    applyStimulus(b, zeros(b.size()), 2, -1);
    settle();
    checkOutput("recoverStat", 32'(statGood), 32'd1);
    checkOutput("recoverLast", 32'(lastCount), 32'd7);

    for (int r = 0; r < 60; r++) begin
      kind   = $urandom_range(0, 19);
      preLen = $urandom_range(1, 8);
      d.delete();
      if (kind <= 1) begin
        b.delete();
        for (int i = 0; i < preLen; i++) b.push_back(8'h55);
        b.push_back(8'hD5);
        for (int i = 0; i < $urandom_range(0, 4); i++) b.push_back(8'($urandom));
      end else begin
        if (kind == 3) begin
          for (int i = 0; i < 1514 + $urandom_range(0, 1); i++) d.push_back(8'($urandom));
        end else begin
          for (int i = 0; i < $urandom_range(0, 70); i++) d.push_back(8'($urandom));
        end
        b = makeFrame(d, ($urandom_range(0, 4) == 0), preLen);
        if (kind == 2) b[$urandom_range(0, preLen - 1)] = 8'($urandom);
      end
      erq.delete();
      for (int i = 0; i < b.size(); i++) erq.push_back($urandom_range(0, 59) == 0);
      applyStimulus(b, erq, $urandom_range(1, 3), -1);
    end

    settle();
    repeat (3) @(negedge clk);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
